// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, FSM states and byte-lane helpers for the load/store unit
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1,
        S_RESP
    } state_t;

    // Beat 1 gets the lanes that spilled past the top of the bus word.
    function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] off,
                                           input logic beat, input logic [3:0] nb);
        logic [7:0] mask;
        mask = 8'((9'd1 << (4'd1 << size)) - 9'd1);
        if (beat)
            be_mask = mask >> (nb - {1'b0, off});
        else
            be_mask = 8'({8'b0, mask} << off);
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] data, input logic [1:0] size,
                                           input logic uns);
        case (size)
            SZ_B:    extend = {{56{~uns & data[7]}},  data[7:0]};
            SZ_H:    extend = {{48{~uns & data[15]}}, data[15:0]};
            SZ_W:    extend = {{32{~uns & data[31]}}, data[31:0]};
            default: extend = data;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane rotation and load merge/extension
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int OFFW = (XLEN == 64) ? 3 : 2
) (
    input  logic [OFFW-1:0] st_off,
    input  logic [XLEN-1:0] st_data,
    output logic [XLEN-1:0] st_rot,
    input  logic [OFFW-1:0] ld_off,
    input  logic [1:0]      ld_size,
    input  logic            ld_uns,
    input  logic [XLEN-1:0] rdata0,
    input  logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] ld_data
);

    localparam int SHW = OFFW + 4;

    // Rotate left by 8*off == low half of the doubled word shifted right by XLEN-8*off.
    logic [SHW-1:0] st_sh;
    assign st_sh  = SHW'(XLEN) - SHW'({st_off, 3'b000});
    assign st_rot = XLEN'({st_data, st_data} >> st_sh);

    assign ld_data = XLEN'(extend(64'(XLEN'({rdata1, rdata0} >> {ld_off, 3'b000})),
                                  ld_size, ld_uns));

endmodule

// File: rtl/lsu_split.sv
// rtl/lsu_split.sv - load/store unit splitting word-crossing accesses into two aligned bus beats
module lsu_split
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SPLIT_MISALIGNED = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = (XLEN == 64) ? 3 : 2;

    state_t          state;
    logic            r_we, r_uns, r_cross;
    logic [1:0]      r_size;
    logic [OFFW-1:0] r_off;
    logic [XLEN-1:0] rdata0_q;

    logic [OFFW-1:0] in_off;
    logic [3:0]      in_end;
    logic            in_cross, in_illegal;
    logic [XLEN-1:0] wdata_rot, ld_data;

    assign in_off     = req_addr[OFFW-1:0];
    assign in_end     = 4'(in_off) + (4'd1 << req_size);
    assign in_cross   = in_end > 4'(NB);
    assign in_illegal = (req_size == SZ_D && XLEN == 32) || (in_cross && SPLIT_MISALIGNED == 0);
    assign req_ready  = (state == S_IDLE) && !rst;

    // The beat-0 read data is merged straight off the bus when no second beat follows.
    lsu_align #(.XLEN(XLEN)) u_align (
        .st_off  (in_off),
        .st_data (req_wdata),
        .st_rot  (wdata_rot),
        .ld_off  (r_off),
        .ld_size (r_size),
        .ld_uns  (r_uns),
        .rdata0  ((state == S_WAIT0) ? mem_rdata : rdata0_q),
        .rdata1  (mem_rdata),
        .ld_data (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            r_we      <= 1'b0;
            r_uns     <= 1'b0;
            r_cross   <= 1'b0;
            r_size    <= SZ_B;
            r_off     <= '0;
            rdata0_q  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: if (req_valid) begin
                    r_we    <= req_we;
                    r_uns   <= req_unsigned;
                    r_size  <= req_size;
                    r_off   <= in_off;
                    r_cross <= in_cross;
                    if (in_illegal) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        state     <= S_REQ0;
                        mem_req   <= 1'b1;
                        mem_we    <= req_we;
                        mem_addr  <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                        mem_be    <= NB'(be_mask(req_size, 3'(in_off), 1'b0, 4'(NB)));
                        mem_wdata <= wdata_rot;
                    end
                end
                S_REQ0: if (mem_gnt) begin
                    mem_req <= 1'b0;
                    state   <= S_WAIT0;
                end
                S_WAIT0: if (mem_rvalid) begin
                    rdata0_q <= mem_rdata;
                    if (r_cross) begin
                        state    <= S_REQ1;
                        mem_req  <= 1'b1;
                        mem_addr <= mem_addr + XLEN'(NB);
                        mem_be   <= NB'(be_mask(r_size, 3'(r_off), 1'b1, 4'(NB)));
                    end else begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= r_we ? '0 : ld_data;
                    end
                end
                S_REQ1: if (mem_gnt) begin
                    mem_req <= 1'b0;
                    state   <= S_WAIT1;
                end
                S_WAIT1: if (mem_rvalid) begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= r_we ? '0 : ld_data;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_split.md
# lsu_split

Sequential, parametrised load/store unit between the core execute stage and the data-memory port. It accepts one load or store per handshake and drives a req/gnt/rvalid memory bus. Misaligned accesses that straddle a bus word are split into two aligned beats, and load data is merged, shifted and sign- or zero-extended. Store data is lane-rotated with per-byte enables, so the core never handles alignment.

## Interface
- `XLEN`, default 32: data/address width; 32 or 64 only.
- `SPLIT_MISALIGNED`, default 1: 1 splits word-crossing accesses into two beats; 0 reports them as errors.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: core request valid.
- `req_ready` out 1: unit can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: access size; 0 byte, 1 half, 2 word, 3 double (XLEN=64 only).
- `req_unsigned` in 1: load zero-extends when 1.
- `req_addr` in XLEN: byte address.
- `req_wdata` in XLEN: store data, LSB-aligned.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out XLEN: extended load data; 0 for stores and errors.
- `rsp_err` out 1: error, qualified by `rsp_valid`.
- `mem_req` out 1: memory request.
- `mem_gnt` in 1: memory accepts the request this cycle.
- `mem_addr` out XLEN: bus-word-aligned address.
- `mem_we` out 1: memory write.
- `mem_be` out NB=XLEN/8: byte enables.
- `mem_wdata` out XLEN: lane-rotated store data.
- `mem_rvalid` in 1: beat completion; carries read data or store acknowledge.
- `mem_rdata` in XLEN: read data.

## Operation
- Derived values: off = addr mod NB; nbytes = 1<<size; cross = off+nbytes > NB.
- Illegal request: size 3 with XLEN=32, or cross with SPLIT_MISALIGNED=0. Result: no memory beat; state goes to RESP with rsp_err=1.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
  - IDLE: req_ready=1. On req_valid, register the request and go to REQ0, or to RESP if illegal.
  - REQ0: mem_req=1. On mem_gnt, go to WAIT0.
  - WAIT0: on mem_rvalid, capture rdata, then go to REQ1 if cross, else RESP.
  - REQ1 / WAIT1: same as REQ0 / WAIT0, then RESP.
  - RESP: rsp_valid=1 for one cycle, then IDLE.
- Beat 0 signals:
  - mem_addr = addr & ~(NB-1).
  - mem_be = ((1<<nbytes)-1)<<off, truncated to NB bits.
  - mem_wdata = req_wdata rotated left by 8*off.
- Beat 1 signals:
  - mem_addr = beat0 address + NB, wrapping modulo 2^XLEN.
  - mem_be = ((1<<nbytes)-1) >> (NB-off).
  - mem_wdata is the same rotated data as beat 0.
- Load merge: (rdata0 >> 8*off) OR (rdata1 << 8*(NB-off)), masked to nbytes, then sign- or zero-extended to XLEN.
- Only one transaction is outstanding. mem_rvalid outside WAIT0/WAIT1 is ignored.
- mem_req, mem_addr, mem_be, mem_wdata and mem_we stay stable from assertion until mem_gnt.
- The memory protocol guarantees rvalid comes strictly after its gnt.

## Timing
- Request accepted at cycle 0. With gnt at the first mem_req and rvalid one cycle after gnt:
  - Unsplit: mem_req at cycle 1, rsp_valid at cycle 3.
  - Split: rsp_valid at cycle 5.
  - Illegal: rsp_valid at cycle 1.
- Every gnt or rvalid stall adds one cycle per stalled cycle.
- rsp_valid has no backpressure.
- rsp_rdata and rsp_err are registered and hold until the next response.
- All memory outputs are registered.
- Reset values: state IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_valid, rsp_err and rsp_rdata all 0. req_ready is 0 while rst is high and 1 in the first cycle after release.
- Reset mid-operation: drops mem_req immediately, discards the transaction, produces no response. The first post-reset mem_rvalid is ignored.

## Structure
- Package `lsu_pkg` holds:
  - size encoding localparams;
  - the FSM state enum;
  - functions `be_mask(size,off,beat)` and `extend(data,size,unsigned)`.
- Sub-module `lsu_align` (combinational) performs store rotation and load merge/extension. The FSM, registers and handshake stay in `lsu_split`.

## Test plan
- LW, addr 0x100, rdata 0xDEADBEEF, immediate gnt:
  - one beat, mem_be=1111;
  - rsp_valid at cycle 3 with rsp_rdata=0xDEADBEEF, rsp_err=0.
- Signed LH, addr 0x103:
  - beat0: addr 0x100, be=1000, rdata 0xAB000000;
  - beat1: addr 0x104, be=0001, rdata 0x000000CD;
  - response rsp_rdata=0xFFFFCDAB at cycle 5.
- SW, addr 0x102, wdata 0x11223344:
  - beat0: addr 0x100, be=1100, wdata 0x33441122;
  - beat1: addr 0x104, be=0011, same wdata;
  - response rsp_rdata=0.
- SPLIT_MISALIGNED=0, LW 0x101:
  - no mem_req;
  - rsp_valid with rsp_err=1, rsp_rdata=0 at cycle 1.
- mem_gnt held low 4 cycles:
  - mem_req/addr/be/wdata stable;
  - req_ready=0, new req_valid ignored;
  - latency grows by exactly 4.
- rst asserted during WAIT1:
  - mem_req=0 asynchronously;
  - no rsp_valid;
  - subsequent stray mem_rvalid ignored;
  - next LB completes normally.
